// File: rtl/zube_mbox_sequencer_if.sv
// Wishbone master bundle between the zube mailbox sequencer and the zube slave.
interface zube_mbox_sequencer_if;
    logic        wbm_cyc_out;
    logic        wbm_stb_out;
    logic        wbm_we_out;
    logic [31:0] wbm_addr_out;
    logic [31:0] wbm_data_out;
    logic        wbm_ack_in;
    logic [31:0] wbm_data_in;

    modport master (
        output wbm_cyc_out, wbm_stb_out, wbm_we_out, wbm_addr_out, wbm_data_out,
        input  wbm_ack_in, wbm_data_in
    );

    modport slave (
        input  wbm_cyc_out, wbm_stb_out, wbm_we_out, wbm_addr_out, wbm_data_out,
        output wbm_ack_in, wbm_data_in
    );
endinterface

// File: rtl/zube_mbox_sequencer.sv
// Services the zube Z80 mailbox: fetches RX bytes and status on IRQ, drains a host
// TX stream, all through one Wishbone master port with a single outstanding cycle.
module zube_mbox_sequencer #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h3000_0000,
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter int          TIMEOUT_CYCLES  = 16,
    parameter int          TX_GAP          = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       irq_data_in,
    input  logic                       irq_status_in,
    zube_mbox_sequencer_if.master      wbm,
    output logic [7:0]                 rx_data,
    output logic                       rx_valid,
    input  logic                       rx_pop,
    output logic [FIFO_DEPTH_LOG2:0]   rx_count,
    output logic [7:0]                 status_byte,
    output logic                       status_new,
    input  logic                       status_ack,
    input  logic [7:0]                 tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic                       timeout_err
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(TX_GAP + 1);

    typedef enum logic [2:0] {IDLE, RD_DATA, RD_STATUS, WR_DATA, SETTLE} state_t;

    state_t                     state;
    logic [TMO_W-1:0]           tmo_cnt;
    logic [GAP_W-1:0]           gap_cnt;
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic                       fifo_full;
    logic                       want_data;
    logic                       sel_data;
    logic                       sel_status;
    logic                       sel_tx;
    logic                       in_xfer;
    logic                       xfer_ack;
    logic                       xfer_timeout;
    logic                       push;
    logic                       pop;
    logic                       unused_rdata_hi;

    assign unused_rdata_hi = ^wbm.wbm_data_in[31:8];

    assign fifo_full  = (rx_count == (FIFO_DEPTH_LOG2 + 1)'(DEPTH));
    assign want_data  = irq_data_in && !fifo_full;
    assign sel_data   = (state == IDLE) && want_data;
    assign sel_status = (state == IDLE) && !want_data && irq_status_in;
    assign sel_tx     = (state == IDLE) && !want_data && !irq_status_in &&
                        tx_valid && (gap_cnt == '0);
    assign tx_ready   = sel_tx && !reset;

    assign in_xfer      = (state == RD_DATA) || (state == RD_STATUS) || (state == WR_DATA);
    assign xfer_ack     = in_xfer && wbm.wbm_ack_in;
    assign xfer_timeout = in_xfer && !wbm.wbm_ack_in &&
                          (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign push         = xfer_ack && (state == RD_DATA);
    assign pop          = rx_pop && rx_valid;

    assign rx_valid = (rx_count != '0);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

    // Arbitration, bus outputs and bookkeeping; a timed-out cycle updates nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            wbm.wbm_cyc_out  <= 1'b0;
            wbm.wbm_stb_out  <= 1'b0;
            wbm.wbm_we_out   <= 1'b0;
            wbm.wbm_addr_out <= 32'h0;
            wbm.wbm_data_out <= 32'h0;
            tmo_cnt          <= '0;
            gap_cnt          <= '0;
            status_byte      <= 8'h00;
            status_new       <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            if (gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            if (status_ack)
                status_new <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (sel_data) begin
                        state            <= RD_DATA;
                        wbm.wbm_cyc_out  <= 1'b1;
                        wbm.wbm_stb_out  <= 1'b1;
                        wbm.wbm_we_out   <= 1'b0;
                        wbm.wbm_addr_out <= BASE_ADDRESS + 32'd4;
                    end else if (sel_status) begin
                        state            <= RD_STATUS;
                        wbm.wbm_cyc_out  <= 1'b1;
                        wbm.wbm_stb_out  <= 1'b1;
                        wbm.wbm_we_out   <= 1'b0;
                        wbm.wbm_addr_out <= BASE_ADDRESS + 32'd8;
                    end else if (sel_tx) begin
                        state            <= WR_DATA;
                        wbm.wbm_cyc_out  <= 1'b1;
                        wbm.wbm_stb_out  <= 1'b1;
                        wbm.wbm_we_out   <= 1'b1;
                        wbm.wbm_addr_out <= BASE_ADDRESS + 32'd4;
                        wbm.wbm_data_out <= {24'h0, tx_data};
                    end
                end
                RD_DATA, RD_STATUS, WR_DATA: begin
                    if (wbm.wbm_ack_in || xfer_timeout) begin
                        state           <= SETTLE;
                        wbm.wbm_cyc_out <= 1'b0;
                        wbm.wbm_stb_out <= 1'b0;
                        wbm.wbm_we_out  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    if (xfer_timeout)
                        timeout_err <= 1'b1;
                    if (xfer_ack && state == RD_STATUS) begin
                        status_byte <= wbm.wbm_data_in[7:0];
                        status_new  <= 1'b1;
                    end
                    if (xfer_ack && state == WR_DATA)
                        gap_cnt <= GAP_W'(TX_GAP);
                end
                SETTLE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RX FIFO; a full FIFO is never read into because IDLE will not select RD_DATA.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'h00;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wbm.wbm_data_in[7:0];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                rx_count <= rx_count + 1'b1;
            else if (!push && pop)
                rx_count <= rx_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_zube_mbox_sequencer.sv
// Directed bench for zube_mbox_sequencer with a latency-configurable Wishbone slave
// and a log of every acknowledged bus cycle.
module tb_zube_mbox_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       irq_data_in;
    logic       irq_status_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_pop;
    logic [3:0] rx_count;
    logic [7:0] status_byte;
    logic       status_new;
    logic       status_ack;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       timeout_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    zube_mbox_sequencer_if bus();

    zube_mbox_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .irq_data_in   (irq_data_in),
        .irq_status_in (irq_status_in),
        .wbm           (bus),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_pop        (rx_pop),
        .rx_count      (rx_count),
        .status_byte   (status_byte),
        .status_new    (status_new),
        .status_ack    (status_ack),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .timeout_err   (timeout_err)
    );

    // Slave: acks slave_lat cycles after first seeing the strobe, unless muted.
    logic        slave_en;
    int          slave_lat;
    logic [31:0] data_val;
    logic [31:0] status_val;
    int          wait_cnt = 0;

    always @(posedge clk) begin
        if (bus.wbm_cyc_out && bus.wbm_stb_out && !bus.wbm_ack_in && slave_en) begin
            if (wait_cnt >= slave_lat) begin
                bus.wbm_ack_in  <= 1'b1;
                bus.wbm_data_in <= (bus.wbm_addr_out == 32'h3000_0008) ? status_val : data_val;
                wait_cnt        <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            bus.wbm_ack_in <= 1'b0;
            wait_cnt       <= 0;
        end
    end

    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    logic        log_we   [64];
    int          log_cyc  [64];
    int          n_log = 0;
    int          cycle = 0;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (bus.wbm_cyc_out && bus.wbm_stb_out && bus.wbm_ack_in && n_log < 64) begin
            log_addr[n_log] <= bus.wbm_addr_out;
            log_we[n_log]   <= bus.wbm_we_out;
            log_data[n_log] <= bus.wbm_we_out ? bus.wbm_data_out : bus.wbm_data_in;
            log_cyc[n_log]  <= cycle;
            n_log           <= n_log + 1;
        end
    end

    task automatic step(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  base;
        int  prev;
        int  hs_count;
        int  high;
        logic hs;
        logic cyc_seen;

        reset = 1'b1; irq_data_in = 1'b0; irq_status_in = 1'b0; rx_pop = 1'b0;
        status_ack = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        slave_en = 1'b1; slave_lat = 0; data_val = 32'h0; status_val = 32'h0;
        step(3);
        reset = 1'b0;

        $display("[TB] reset and idle");
        cyc_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.wbm_cyc_out !== 1'b0) cyc_seen = 1'b1;
        end
        check_output("idle_cyc_never", cyc_seen, 1'b0);
        check_output("rst_stb", bus.wbm_stb_out, 1'b0);
        check_output("rst_we", bus.wbm_we_out, 1'b0);
        check_output("rst_addr", bus.wbm_addr_out, 32'h0);
        check_output("rst_wdata", bus.wbm_data_out, 32'h0);
        check_output("rst_rx_valid", rx_valid, 1'b0);
        check_output("rst_rx_data", rx_data, 8'h00);
        check_output("rst_rx_count", rx_count, 4'd0);
        check_output("rst_status_byte", status_byte, 8'h00);
        check_output("rst_status_new", status_new, 1'b0);
        check_output("rst_tx_ready", tx_ready, 1'b0);
        check_output("rst_timeout_err", timeout_err, 1'b0);

        $display("[TB] single data read");
        base = n_log; data_val = 32'h0000_005A; slave_lat = 1;
        irq_data_in = 1'b1;
        step();
        irq_data_in = 1'b0;
        for (int i = 0; i < 20 && bus.wbm_ack_in !== 1'b1; i++) step();
        check_output("rd_ack_seen", bus.wbm_ack_in, 1'b1);
        step();
        check_output("rd_cyc_dropped", bus.wbm_cyc_out, 1'b0);
        check_output("rd_count_log", n_log - base, 1);
        check_output("rd_addr", log_addr[base], 32'h3000_0004);
        check_output("rd_we", log_we[base], 1'b0);
        check_output("rd_rx_valid", rx_valid, 1'b1);
        check_output("rd_rx_data", rx_data, 8'h5A);
        check_output("rd_rx_count", rx_count, 4'd1);
        rx_pop = 1'b1; step(); rx_pop = 1'b0;
        check_output("pop_rx_count", rx_count, 4'd0);
        check_output("pop_rx_valid", rx_valid, 1'b0);
        rx_pop = 1'b1; step(); rx_pop = 1'b0;
        check_output("pop_empty_count", rx_count, 4'd0);

        $display("[TB] priority order and tx gap");
        base = n_log; slave_lat = 0; data_val = 32'h77; status_val = 32'h3C;
        tx_data = 8'hC3; tx_valid = 1'b1; irq_data_in = 1'b1; irq_status_in = 1'b1;
        hs_count = 0;
        for (int i = 0; i < 100 && (n_log - base) < 4; i++) begin
            hs = tx_valid && tx_ready;
            step();
            if (hs) begin
                hs_count++;
                if (hs_count == 1) tx_data = 8'h99;
                else tx_valid = 1'b0;
            end
            if (n_log - base >= 1) irq_data_in = 1'b0;
            if (n_log - base >= 2) irq_status_in = 1'b0;
        end
        tx_valid = 1'b0;
        check_output("ord_count", n_log - base, 4);
        check_output("ord0_addr", log_addr[base], 32'h3000_0004);
        check_output("ord0_we", log_we[base], 1'b0);
        check_output("ord1_addr", log_addr[base+1], 32'h3000_0008);
        check_output("ord1_we", log_we[base+1], 1'b0);
        check_output("ord2_addr", log_addr[base+2], 32'h3000_0004);
        check_output("ord2_we", log_we[base+2], 1'b1);
        check_output("ord2_data", log_data[base+2], 32'h0000_00C3);
        check_output("ord3_data", log_data[base+3], 32'h0000_0099);
        check_output("settle_gap_01", log_cyc[base+1] - log_cyc[base], 4);
        check_output("settle_gap_12", log_cyc[base+2] - log_cyc[base+1], 4);
        check_output("tx_gap_23", log_cyc[base+3] - log_cyc[base+2], 11);
        check_output("ord_rx_data", rx_data, 8'h77);
        check_output("ord_status_byte", status_byte, 8'h3C);
        check_output("ord_status_new", status_new, 1'b1);
        rx_pop = 1'b1; step(); rx_pop = 1'b0;
        status_ack = 1'b1; step(); status_ack = 1'b0;
        check_output("ack_status_new", status_new, 1'b0);
        check_output("ack_status_byte", status_byte, 8'h3C);

        $display("[TB] fifo full");
        base = n_log; prev = n_log; data_val = 32'h40;
        irq_data_in = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (n_log != prev) begin
                prev = n_log;
                data_val = data_val + 32'd1;
            end
        end
        check_output("full_reads", n_log - base, 8);
        check_output("full_rx_count", rx_count, 4'd8);
        check_output("full_rx_data", rx_data, 8'h40);
        rx_pop = 1'b1; step(); rx_pop = 1'b0;
        for (int i = 0; i < 20 && (n_log - base) < 9; i++) step();
        irq_data_in = 1'b0;
        check_output("full_ninth_read", n_log - base, 9);
        check_output("full_ninth_data", log_data[base+8], 32'h48);
        check_output("full_refill_count", rx_count, 4'd8);
        check_output("full_head_adv", rx_data, 8'h41);
        for (int k = 1; k <= 8; k++) begin
            check_output($sformatf("drain_%0d", k), rx_data, 32'(8'h40 + k));
            rx_pop = 1'b1; step(); rx_pop = 1'b0;
        end
        check_output("drain_count", rx_count, 4'd0);

        $display("[TB] status timeout");
        slave_en = 1'b0; irq_status_in = 1'b1;
        for (int i = 0; i < 10 && bus.wbm_cyc_out !== 1'b1; i++) step();
        irq_status_in = 1'b0;
        high = 0;
        while (bus.wbm_cyc_out === 1'b1 && high < 40) begin
            high++;
            step();
        end
        check_output("tmo_wait_cycles", high, 16);
        check_output("tmo_stb_low", bus.wbm_stb_out, 1'b0);
        check_output("tmo_err", timeout_err, 1'b1);
        check_output("tmo_status_new", status_new, 1'b0);
        check_output("tmo_status_byte", status_byte, 8'h3C);
        step(2);
        base = n_log; slave_en = 1'b1; status_val = 32'h11;
        irq_status_in = 1'b1; status_ack = 1'b1;
        for (int i = 0; i < 20 && n_log == base; i++) step();
        irq_status_in = 1'b0;
        check_output("sts_fetch_wins", status_new, 1'b1);
        check_output("sts_byte", status_byte, 8'h11);
        step();
        status_ack = 1'b0;
        check_output("sts_ack_clears", status_new, 1'b0);
        check_output("tmo_err_sticky", timeout_err, 1'b1);

        $display("[TB] reset during write");
        base = n_log; data_val = 32'h5A; irq_data_in = 1'b1;
        for (int i = 0; i < 20 && n_log == base; i++) step();
        irq_data_in = 1'b0;
        check_output("pre_rst_count", rx_count, 4'd1);
        step(2);
        slave_en = 1'b0; tx_data = 8'hA5; tx_valid = 1'b1;
        for (int i = 0; i < 20 && tx_ready !== 1'b1; i++) step();
        check_output("wr_tx_ready", tx_ready, 1'b1);
        step();
        tx_valid = 1'b0;
        step(2);
        check_output("wr_cyc", bus.wbm_cyc_out, 1'b1);
        check_output("wr_data", bus.wbm_data_out, 32'h0000_00A5);
        reset = 1'b1;
        step();
        check_output("mid_rst_cyc", bus.wbm_cyc_out, 1'b0);
        check_output("mid_rst_stb", bus.wbm_stb_out, 1'b0);
        check_output("mid_rst_count", rx_count, 4'd0);
        check_output("mid_rst_valid", rx_valid, 1'b0);
        check_output("mid_rst_tmo", timeout_err, 1'b0);
        check_output("mid_rst_tx_ready", tx_ready, 1'b0);
        reset = 1'b0;
        step();
        check_output("post_rst_tx_ready", tx_ready, 1'b0);
        base = n_log; slave_en = 1'b1; tx_data = 8'h3E; tx_valid = 1'b1;
        #1;
        check_output("post_rst_select", tx_ready, 1'b1);
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 20 && n_log == base; i++) step();
        check_output("post_rst_write", n_log - base, 1);
        check_output("post_rst_wdata", log_data[base], 32'h0000_003E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/zube_mbox_sequencer.md
Name: zube_mbox_sequencer

Overview:
Wishbone master that services the zube Z80 mailbox on behalf of the SoC. It watches the mailbox data/status IRQs, fetches incoming Z80 bytes into a local RX FIFO, and latches the Z80 status byte. It also drains a host TX stream into the mailbox DATA register. It sits between the zube slave and SoC firmware and arbitrates a single Wishbone master port between RX-data, RX-status and TX work.

Parameters:
BASE_ADDRESS, 32'h3000_0000, zube base; DATA reg at +4, STATUS reg at +8.
FIFO_DEPTH_LOG2, 3, RX FIFO depth = 2^N entries of 8 bits.
TIMEOUT_CYCLES, 16, maximum cycles to wait for wbm_ack_in before aborting.
TX_GAP, 8, idle cycles enforced after each TX write before the next one.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
irq_data_in  in  1  zube data-written IRQ.
irq_status_in  in  1  zube status-written IRQ.
wbm_cyc_out  out  1  Wishbone cycle.
wbm_stb_out  out  1  Wishbone strobe.
wbm_we_out  out  1  Wishbone write enable.
wbm_addr_out  out  32  Wishbone address.
wbm_data_out  out  32  Wishbone write data, {24'b0, byte}.
wbm_ack_in  in  1  Wishbone ack.
wbm_data_in  in  32  Wishbone read data; bits [7:0] used.
rx_data  out  8  head of RX FIFO, valid when rx_valid is high.
rx_valid  out  1  RX FIFO non-empty.
rx_pop  in  1  consume head; ignored when empty.
rx_count  out  FIFO_DEPTH_LOG2+1  RX FIFO occupancy.
status_byte  out  8  last status byte fetched from Z80.
status_new  out  1  sticky flag set on fetch; cleared by status_ack.
status_ack  in  1  clears status_new.
tx_data  in  8  byte to send to Z80.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  sequencer accepts tx_data this cycle.
timeout_err  out  1  sticky; set on any Wishbone timeout; cleared only by reset.

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE; timeout counter and gap counter 0. Reset mid-transaction drops cyc/stb the next cycle. The in-flight byte is lost.
- FSM states: IDLE, RD_DATA, RD_STATUS, WR_DATA, SETTLE.
- IDLE arbitration uses fixed priority, evaluated each cycle:
  1. irq_data_in && FIFO not full -> RD_DATA.
  2. irq_status_in -> RD_STATUS.
  3. tx_valid && gap counter == 0 -> WR_DATA.
- Bus signals in each transfer state:
  - RD_DATA: cyc=stb=1, we=0, addr=BASE_ADDRESS+4.
  - RD_STATUS: cyc=stb=1, we=0, addr=BASE_ADDRESS+8.
  - WR_DATA: cyc=stb=1, we=1, addr=BASE_ADDRESS+4, data={24'b0, captured tx byte}.
- Signals are registered. They hold stable until ack, and drop in the cycle after ack is sampled.
- tx_ready is high only in the IDLE cycle that selects WR_DATA. tx_data is captured on that edge, so the handshake is tx_valid && tx_ready.
- On ack:
  - RD_DATA pushes wbm_data_in[7:0] into the FIFO.
  - RD_STATUS loads status_byte and sets status_new.
  - WR_DATA loads the gap counter with TX_GAP.
- Every transfer state goes to SETTLE for exactly one cycle, then returns to IDLE. This lets the slave's IRQ clear before re-arbitration.
- Timeout: a per-transaction counter increments while waiting for ack. When it reaches TIMEOUT_CYCLES the FSM drops cyc/stb, sets timeout_err, goes to SETTLE and pushes or updates nothing.
- The gap counter decrements to 0 every cycle independent of state. It does not block RX work.
- FIFO full: a data IRQ is not serviced. The zube IRQ stays asserted (the slave clears it on read), so the read occurs once space frees. No byte is dropped.
- FIFO rules:
  - Push and pop in the same cycle: count is unchanged and head advances.
  - Pop when empty: ignored.
  - Pointers wrap modulo 2^FIFO_DEPTH_LOG2.
  - rx_data is the registered head. It is valid the same cycle rx_valid rises.
- status_ack and a new status fetch in the same cycle: the fetch wins, so status_new stays 1.
- No pipelining: at most one outstanding Wishbone transaction.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, wbm_cyc_out never asserted.
- Pulse irq_data_in; slave acks 2 cycles later with 32'h0000_005A -> one read of 32'h3000_0004, rx_valid=1, rx_data=8'h5A, rx_count=1; FSM idle 1 cycle after ack.
- irq_data_in, irq_status_in and tx_valid (tx_data=8'hC3) all high at once -> order is data read, status read, then write of 32'h0000_00C3 to 32'h3000_0004, with a 1-cycle SETTLE between each. Next tx write comes no sooner than TX_GAP=8 cycles after the first ack.
- Hold irq_data_in high and never pop, 9 acked reads -> exactly 8 reads, rx_count=8. No 9th read while full; one rx_pop causes the 9th read.
- Never ack a status read -> cyc/stb drop after 16 wait cycles, timeout_err=1, status_new stays 0. A subsequent acked status 8'h11 gives status_byte=8'h11 and status_new=1.
- Assert reset during WR_DATA while waiting for ack -> cyc/stb=0 the next cycle, FIFO empty, tx_ready=0 until a new IDLE selection.
